// File: rtl/doc_reg_sequencer.sv
// Bus master that replays queued DOC5503 register commands with programmable
// setup/active/hold phases, returning read data and optional write read-back checks.
module doc_reg_sequencer #(
    parameter int SETUP_CYCLES  = 8,
    parameter int ACTIVE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int VERIFY_WRITES = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_we_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_addr_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_mismatch_o,
    output logic       busy_o,
    input  logic       doc_ready_i,
    output logic       doc_cs_n_o,
    output logic       doc_we_n_o,
    output logic [7:0] doc_addr_o,
    output logic [7:0] doc_data_o,
    input  logic [7:0] doc_data_i
);

    localparam int MAX_SA  = (SETUP_CYCLES > ACTIVE_CYCLES) ? SETUP_CYCLES : ACTIVE_CYCLES;
    localparam int MAX_ALL = (MAX_SA > HOLD_CYCLES) ? MAX_SA : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] S_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(ACTIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACTIVE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_VSETUP  = 3'd4;
    localparam logic [2:0] ST_VACTIVE = 3'd5;
    localparam logic [2:0] ST_VHOLD   = 3'd6;

    // Command handshake: a command transfers on any clock edge where cmd_valid_i
    // and cmd_ready_o are both high; ready depends only on FIFO fullness.
    logic [16:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             fifo_full, fifo_empty, push, pop;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_addr_q, rsp_addr_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_mm_q, rsp_mm_d;
    logic             last;
    logic [16:0]      head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = cmd_valid_i && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty && doc_ready_i;
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign last       = (cnt_q == '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = last ? cnt_q : cnt_q - CNT_ONE;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_mm_d    = rsp_mm_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    state_d = ST_SETUP;
                    cnt_d   = S_LAST;
                    we_d    = head[16];
                    addr_d  = head[15:8];
                    wdata_d = head[7:0];
                end
            end
            ST_SETUP: if (last) begin
                state_d = ST_ACTIVE;
                cnt_d   = A_LAST;
            end
            ST_ACTIVE: if (last) begin
                state_d = ST_HOLD;
                cnt_d   = H_LAST;
                if (!we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = addr_q;
                    rsp_data_d  = doc_data_i;
                    rsp_mm_d    = 1'b0;
                end
            end
            ST_HOLD: if (last) begin
                if (we_q && (VERIFY_WRITES != 0)) begin
                    state_d = ST_VSETUP;
                    cnt_d   = S_LAST;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_VSETUP: if (last) begin
                state_d = ST_VACTIVE;
                cnt_d   = A_LAST;
            end
            ST_VACTIVE: if (last) begin
                // Read-back sample is judged against the data that was written.
                state_d     = ST_VHOLD;
                cnt_d       = H_LAST;
                rsp_valid_d = 1'b1;
                rsp_addr_d  = addr_q;
                rsp_data_d  = doc_data_i;
                rsp_mm_d    = (doc_data_i != wdata_q);
            end
            ST_VHOLD: if (last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_we_i, cmd_addr_i, cmd_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_mm_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mm_q    <= rsp_mm_d;
        end
    end

    assign cmd_ready_o    = !fifo_full;
    assign busy_o         = (state_q != ST_IDLE) || !fifo_empty;
    assign doc_cs_n_o     = !((state_q == ST_ACTIVE) || (state_q == ST_VACTIVE));
    assign doc_we_n_o     = !((state_q == ST_ACTIVE) && we_q);
    assign doc_addr_o     = addr_q;
    assign doc_data_o     = wdata_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_addr_o     = rsp_addr_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_mismatch_o = rsp_mm_q;

endmodule

// File: doc/doc_reg_sequencer.md
# doc_reg_sequencer

Parametrised bus master that executes queued register read/write commands against the DOC5503 host port. It drives `cs_n`, `we_n`, `addr` and `data` with programmable setup, active and hold phase lengths, and returns read data. An optional mode reads back every write and flags mismatches. It sits between a configuration source (CPU bridge or boot ROM walker) and `doc5503`, replacing hand-timed bus cycles.

## Interface
- `SETUP_CYCLES`, default 8: cycles with address and data valid and `cs_n` high before assertion; must be ≥1.
- `ACTIVE_CYCLES`, default 16: cycles with `cs_n` low; must be ≥1.
- `HOLD_CYCLES`, default 8: cycles with `cs_n` high after deassertion; must be ≥1.
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of two, ≥2.
- `VERIFY_WRITES`, default 0: 1 means every write is followed by a read-back of the same address.

Ports:
- `clk_i`, in, 1: single clock.
- `reset_i`, in, 1: reset, synchronous, active-high.
- `cmd_valid_i`, in, 1: command offered.
- `cmd_ready_o`, out, 1: FIFO not full.
- `cmd_we_i`, in, 1: 1 = write, 0 = read.
- `cmd_addr_i`, in, 8: register address.
- `cmd_data_i`, in, 8: write data.
- `rsp_valid_o`, out, 1: one-cycle response pulse.
- `rsp_addr_o`, out, 8: address of the responding command.
- `rsp_data_o`, out, 8: data captured from the DOC.
- `rsp_mismatch_o`, out, 1: verified write read back a different value.
- `busy_o`, out, 1: FSM not in IDLE, or FIFO not empty.
- `doc_ready_i`, in, 1: DOC `ready_o`; gates the start of each transaction.
- `doc_cs_n_o`, out, 1: DOC chip select.
- `doc_we_n_o`, out, 1: DOC write enable.
- `doc_addr_o`, out, 8: DOC address.
- `doc_data_o`, out, 8: DOC write data.
- `doc_data_i`, in, 8: DOC read data.

## Operation
- **Command FIFO**
  - A command is pushed when `cmd_valid_i && cmd_ready_o`.
  - `cmd_ready_o = !full`. It is not relieved by a same-cycle pop.
- **FSM states**: IDLE, SETUP, ACTIVE, HOLD, VSETUP, VACTIVE, VHOLD.
- **IDLE**
  - When the FIFO is non-empty and `doc_ready_i` is high: pop, latch the command, load `doc_addr_o` and `doc_data_o`, go to SETUP.
  - With `doc_ready_i` low, no pop occurs.
- **SETUP**: `cs_n` = 1, `we_n` = 1. Lasts `SETUP_CYCLES`, then ACTIVE.
- **ACTIVE**
  - `cs_n` = 0 and `we_n = !we`. Lasts `ACTIVE_CYCLES`.
  - `doc_data_i` is captured on the last ACTIVE cycle. Then go to HOLD.
- **HOLD**
  - `cs_n` = 1, `we_n` = 1. Lasts `HOLD_CYCLES`.
  - On exit: if the command was a write and `VERIFY_WRITES` = 1, go to VSETUP; otherwise go to IDLE.
- **Verify phases (VSETUP, VACTIVE, VHOLD)**
  - Same timing as SETUP, ACTIVE and HOLD, with `we_n` held at 1.
  - The capture is compared against the latched write data.
- **Responses**
  - Reads and verify read-backs pulse `rsp_valid_o` on the first HOLD or VHOLD cycle.
  - `rsp_mismatch_o` = 1 only for a verify read-back whose data differs; it is 0 for plain reads.
  - Unverified writes produce no response.
- **Phase counter**: width `$clog2(max(S,A,H)+1)`. It reloads on every state change.
- **`doc_ready_i` falling mid-transaction**: the transaction completes normally; the next start waits for `doc_ready_i`.
- **Command order** is strictly FIFO order.

## Timing
- **Reset values**:
  - `doc_cs_n_o` = 1, `doc_we_n_o` = 1.
  - `doc_addr_o` = 0, `doc_data_o` = 0.
  - `rsp_valid_o` = 0, `rsp_addr_o` = 0, `rsp_data_o` = 0, `rsp_mismatch_o` = 0.
  - `busy_o` = 0, `cmd_ready_o` = 1.
  - FIFO empty, FSM in IDLE.
- **Reset mid-transaction**: the FSM aborts, `cs_n`/`we_n` return high on the cycle after reset, queued commands are discarded, and no response is issued.
- **Latency of a push into an empty FIFO**
  - Pop occurs 1 cycle after the push.
  - First SETUP cycle is 1 cycle after the pop.
  - `cs_n` falls `SETUP_CYCLES` later.
- **Transaction length**: an unverified transaction occupies 1 + S + A + H cycles from pop to the next possible pop (33 at defaults). A verified write adds S + A + H.
- **Response timing**: `rsp_valid_o` asserts exactly A cycles after `cs_n` falls, and the `rsp_*` fields are valid that cycle.

## Test plan
- **Write, defaults**: write E1=01. Required: `cs_n`/`we_n` low for exactly 16 cycles, falling 8 cycles after SETUP entry; `doc_addr_o` = E1 and `doc_data_o` = 01 throughout; no `rsp_valid_o`.
- **Read**: read 40 with the DOC model returning FF. Required: one `rsp_valid_o` pulse with `rsp_addr_o` = 40, `rsp_data_o` = FF, `rsp_mismatch_o` = 0; `we_n` stays 1.
- **Verify mode**: with `VERIFY_WRITES` = 1, write 20=0F while the model returns 0E. Required: response `rsp_data_o` = 0E, `rsp_mismatch_o` = 1. Repeat with the model returning 0F: `rsp_mismatch_o` = 0.
- **FIFO full and ordering**: with `doc_ready_i` low, push 5 commands. Required: `cmd_ready_o` low after the 4th, the 5th is not accepted. Raise `doc_ready_i`: the 4 commands execute in order, `cs_n` falls 33 cycles apart.
- **Reset mid-ACTIVE**: assert `reset_i` for 1 cycle during ACTIVE with 2 commands queued. Required: `cs_n` = 1 the next cycle, `busy_o` = 0, no response, FIFO empty.
- **Non-default parameters**: S=1, A=1, H=1. Required: `cs_n` low exactly 1 cycle, transactions 4 cycles apart.
